display_mode_ctrl: RTL
======================

// Module: display_mode_ctrl
//
// PURPOSE
//   Run-time video mode controller for a runtime-configurable display_timings
//   generator. Accepts a mode-change request and waits for the current frame
//   to finish. It then holds the timing generator in reset, drives the new
//   timing configuration and releases reset. Sits between the system control
//   logic and the timing generator, in the pixel clock domain.
//
// PARAMETERS
//   DEF_MODE    2'd0   mode loaded at reset (0=640x480p60 1=1280x720p60 2=800x600p60 3=1920x1080p60)
//   RST_CYCLES  8      cycles o_tg_rst is held during a switch (>=2)
//   TIMEOUT     2500000  max cycles to wait for i_frame before forcing the switch
//
// PORTS
//   i_pixclk    in   1   pixel clock
//   i_rst       in   1   asynchronous reset, active-high
//   i_req       in   1   mode-change request (sampled only when o_busy=0)
//   i_mode      in   2   requested mode, valid with i_req
//   i_frame     in   1   one-tick start-of-frame pulse from the timing generator
//   o_busy      out  1   high from the cycle after acceptance until the cycle o_done pulses
//   o_done      out  1   one-cycle pulse: switch complete, new mode active
//   o_timeout   out  1   one-cycle pulse, coincident with leaving WAIT via timeout
//   o_mode      out  2   currently active mode
//   o_tg_rst    out  1   reset to timing generator, active-high
//   o_hcfg      out  64  {H_RES,H_FP,H_SYNC,H_BP}, 16 bits each, MSB first
//   o_vcfg      out  64  {V_RES,V_FP,V_SYNC,V_BP}, 16 bits each, MSB first
//   o_pol       out  2   {H_POL,V_POL}
//
// BEHAVIOUR
// - Mode table (H res,fp,sync,bp / V res,fp,sync,bp / pol):
//   - 0: 640,16,96,48 / 480,10,2,33 / 0,0
//   - 1: 1280,110,40,220 / 720,5,5,20 / 1,1
//   - 2: 800,40,128,88 / 600,1,4,23 / 1,1
//   - 3: 1920,88,44,148 / 1080,4,5,36 / 1,1
// - Reset (async assert):
//   - State HOLD, hold counter=0, o_mode=DEF_MODE.
//   - o_hcfg/o_vcfg/o_pol = table[DEF_MODE], o_tg_rst=1, o_busy=1, o_done=0, o_timeout=0.
//   - Deassertion is synchronised internally (2 flops) before the FSM leaves HOLD.
// - FSM states:
//   - RUN: o_tg_rst=0, o_busy=0.
//     - i_req=1 and i_mode==o_mode: stay in RUN; o_done=1 on the next cycle; no reset, o_busy stays 0.
//     - i_req=1 and i_mode!=o_mode: latch i_mode into pend; go to WAIT. o_busy=1 from the next cycle.
//   - WAIT: old config is still driven. The wait counter increments every cycle.
//     - i_frame=1: go to HOLD on the next edge.
//     - Counter reaches TIMEOUT-1 with no i_frame: go to HOLD and pulse o_timeout.
//     - i_frame and timeout in the same cycle: treat as i_frame (no o_timeout).
//   - HOLD:
//     - On the entry edge: o_tg_rst=1; o_mode, o_hcfg, o_vcfg and o_pol take the values for pend.
//     - Stay exactly RST_CYCLES cycles, then go to RUN.
//     - On the RUN entry edge: o_tg_rst=0, o_done=1 for one cycle, o_busy=0.
// - Latency:
//   - i_frame seen at cycle F -> o_tg_rst high at F+1..F+RST_CYCLES.
//   - o_done at F+RST_CYCLES+1.
// - After reset: HOLD runs RST_CYCLES, then RUN with o_done pulse (signals initial mode ready).
// - Request handling:
//   - i_req while o_busy=1 is ignored; no queueing; the requester must retry.
//   - i_mode is ignored when i_req=0.
// - Config outputs change only on the HOLD entry edge (glitch-free, registered).
// - i_rst mid-switch: immediate return to the reset state with DEF_MODE; pend is discarded.
// - Counters:
//   - Wait counter: $clog2(TIMEOUT) bits, cleared on entry to WAIT.
//   - Hold counter: $clog2(RST_CYCLES+1) bits, cleared on entry to HOLD.
//
// TESTING
// 1. Reset, DEF_MODE=0, RST_CYCLES=8.
//    -> o_tg_rst=1 for 8 cycles after sync release; o_done pulse; o_hcfg={640,16,96,48}; o_pol=2'b00.
// 2. In RUN, i_req with i_mode=1, i_frame pulsed 100 cycles later.
//    -> o_busy; o_tg_rst high for exactly 8 cycles starting 1 cycle after i_frame.
//    -> o_vcfg={720,5,5,20}; o_mode=1; single o_done.
// 3. i_req with i_mode equal to o_mode.
//    -> o_done next cycle; o_tg_rst never asserts; o_busy stays 0.
// 4. TIMEOUT=50, request mode 3, i_frame held low.
//    -> o_timeout at wait cycle 50; then HOLD.
//    -> o_hcfg={1920,88,44,148}; o_done.
// 5. Second i_req (mode 2) during WAIT for mode 1.
//    -> ignored; final o_mode=1; exactly one o_done.
// 6. Assert i_rst during HOLD of a 0->3 switch.
//    -> all outputs return to reset values immediately; o_mode=0.
//    -> recovery matches test 1.
// Also: closed-loop with display_timings for modes 0 and 1; check one full frame of de/hs/vs after each switch.

Source files
------------

// File: rtl/display_mode_ctrl.sv
// Run-time video mode controller: waits for frame end, holds the timing
// generator in reset while the new mode table entry is loaded, then releases it.
module display_mode_ctrl #(
    parameter logic [1:0] DEF_MODE   = 2'd0,
    parameter int         RST_CYCLES = 8,
    parameter int         TIMEOUT    = 2500000
) (
    input  logic        i_pixclk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [1:0]  i_mode,
    input  logic        i_frame,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic [1:0]  o_mode,
    output logic        o_tg_rst,
    output logic [63:0] o_hcfg,
    output logic [63:0] o_vcfg,
    output logic [1:0]  o_pol
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HCW = $clog2(RST_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HOLD} state_t;

    function automatic logic [63:0] mode_hcfg(input logic [1:0] m);
        case (m)
            2'd0:    mode_hcfg = {16'd640,  16'd16,  16'd96,  16'd48};
            2'd1:    mode_hcfg = {16'd1280, 16'd110, 16'd40,  16'd220};
            2'd2:    mode_hcfg = {16'd800,  16'd40,  16'd128, 16'd88};
            default: mode_hcfg = {16'd1920, 16'd88,  16'd44,  16'd148};
        endcase
    endfunction

    function automatic logic [63:0] mode_vcfg(input logic [1:0] m);
        case (m)
            2'd0:    mode_vcfg = {16'd480,  16'd10, 16'd2, 16'd33};
            2'd1:    mode_vcfg = {16'd720,  16'd5,  16'd5, 16'd20};
            2'd2:    mode_vcfg = {16'd600,  16'd1,  16'd4, 16'd23};
            default: mode_vcfg = {16'd1080, 16'd4,  16'd5, 16'd36};
        endcase
    endfunction

    function automatic logic [1:0] mode_pol(input logic [1:0] m);
        mode_pol = (m == 2'd0) ? 2'b00 : 2'b11;
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     rst_sync_q;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [1:0]     pend_q, pend_d;
    logic [1:0]     mode_q, mode_d;
    logic [63:0]    hcfg_q, hcfg_d;
    logic [63:0]    vcfg_q, vcfg_d;
    logic [1:0]     pol_q, pol_d;
    logic           done_q, done_d;
    logic           timeout;
    logic           rst_int;

    // Release of i_rst is resynchronised; the hold counter stays frozen until then.
    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    always_ff @(posedge i_pixclk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_HOLD;
            wcnt_q  <= '0;
            hcnt_q  <= '0;
            pend_q  <= DEF_MODE;
            mode_q  <= DEF_MODE;
            hcfg_q  <= mode_hcfg(DEF_MODE);
            vcfg_q  <= mode_vcfg(DEF_MODE);
            pol_q   <= mode_pol(DEF_MODE);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            hcfg_q  <= hcfg_d;
            vcfg_q  <= vcfg_d;
            pol_q   <= pol_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hcnt_d  = hcnt_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        hcfg_d  = hcfg_q;
        vcfg_d  = vcfg_q;
        pol_d   = pol_q;
        done_d  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_RUN: begin
                if (i_req) begin
                    if (i_mode == mode_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_d  = i_mode;
                        wcnt_d  = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                // A frame edge in the timeout cycle wins: no timeout pulse.
                if (i_frame || wcnt_q == WAIT_LAST) begin
                    timeout = !i_frame;
                    state_d = S_HOLD;
                    hcnt_d  = '0;
                    mode_d  = pend_q;
                    hcfg_d  = mode_hcfg(pend_q);
                    vcfg_d  = mode_vcfg(pend_q);
                    pol_d   = mode_pol(pend_q);
                end
            end
            S_HOLD: begin
                if (!rst_int) begin
                    if (hcnt_q == HOLD_LAST) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    assign o_busy    = (state_q != S_RUN);
    assign o_tg_rst  = (state_q == S_HOLD);
    assign o_done    = done_q;
    assign o_timeout = timeout;
    assign o_mode    = mode_q;
    assign o_hcfg    = hcfg_q;
    assign o_vcfg    = vcfg_q;
    assign o_pol     = pol_q;

endmodule
